rate_divider_tick: RTL and testbench
====================================

Name: rate_divider_tick

Overview:
Upstream enable generator for the 8-bit display counter. Divides the board clock into a one-cycle `tick` pulse at a switch-selected rate. `tick` drives the counter's enable input, so the hex displays advance at a human-visible rate instead of once per clock. The block contains one down-counter with reload logic and a registered rate select.

Parameters:
CLK_HZ, 50000000, board clock frequency; sets the 1 Hz reload value (CLK_HZ-1).
CNT_W, 28, down-counter width; must hold 4*CLK_HZ-1.

Ports:
clk  input  1  system clock, rising edge.
clear  input  1  asynchronous, active-high reset.
run  input  1  1 = counting enabled; 0 = pause (hold count).
rate_sel  input  2  00 = every cycle, 01 = 1 Hz, 10 = 0.5 Hz, 11 = 0.25 Hz.
tick  output  1  registered one-cycle enable pulse to the downstream counter.
count  output  CNT_W  current down-counter value, for debug and verification.
step_n  input  1  present only with RATE_STEP_EN; active-low pushbutton.

Behaviour:
- Clock and reset: one clock (`clk`); `clear` is asynchronous and active-high.
- Reset values while `clear` is high: `count`=0, `tick`=0, `sel_q` (registered `rate_sel`)=00. All are forced immediately, with no clock required.
- Reload value R(s) for select s:
  - R(00)=0
  - R(01)=CLK_HZ-1
  - R(10)=2*CLK_HZ-1
  - R(11)=4*CLK_HZ-1
  - All computed at CNT_W bits; no truncation permitted.
- Each rising `clk` with `clear` low, priority highest first:
  1. `rate_sel` != `sel_q`: `count` <= R(`rate_sel`), `tick` <= 0.
  2. `run`=0: `count` holds, `tick` <= 0.
  3. `count`=0: `count` <= R(`sel_q`), `tick` <= 1.
  4. Otherwise: `count` <= `count`-1, `tick` <= 0.
  - `sel_q` <= `rate_sel` on every clock.
- Tick period: with `run` held at 1 and `rate_sel` stable, `tick` is high exactly 1 cycle in every R(s)+1 cycles.
  - Select 00 gives `tick`=1 every cycle.
- First tick after reset release (`rate_sel` stable, `run`=1):
  - With `rate_sel`=00, `tick` asserts on the 1st clock edge.
  - With `rate_sel` != 00, the 1st edge reloads (mismatch against reset value 00). The first tick follows R+1 edges later.
- Rate change mid-count: the count restarts from the full new period. No tick is emitted on the change edge, and no partial period is carried over.
- Pause: `run` 1->0 freezes `count`, and `tick` drops on that edge. `run` 0->1 resumes from the frozen value, so no cycles are lost or added.
- Simultaneous rate change and `run`=0: the rate change wins, and `count` loads R(new).
- Wrap-around: the counter never decrements below 0; the reload at 0 is the only wrap.
- `clear` asserted mid-period: immediate return to reset values. Any pulse in flight is dropped.
- `tick` is a pure flop output, with no combinational path from inputs.

Optional Feature:
Macro: RATE_STEP_EN.
- Defined:
  - Adds the `step_n` port.
  - `step_n` passes through a 2-flop synchronizer (reset to 1), then a falling-edge detect.
  - When `run`=0 and a falling edge is detected, `tick` <= 1 for one cycle and `count` holds.
  - Step edges while `run`=1 are ignored.
  - Total latency from the `step_n` fall to `tick`: 3 clock edges.
- Not defined: no `step_n` port and no step logic. `run`=0 always yields `tick`=0.

Test Plan:
All scenarios use CLK_HZ=4, so R = 0/3/7/15.
1. `clear` pulse, then `rate_sel`=00, `run`=1 -> `tick`=1 on every edge, starting at the 1st edge; `count` stays 0.
2. `rate_sel`=01, `run`=1 from reset -> edge 1 loads `count`=3; ticks occur at edges 5, 9, 13 (period 4). `count` sequence is 3, 2, 1, 0, 3...
3. `rate_sel`=11 with `count`=9, then switch to 10 -> that edge gives `count`=7, `tick`=0; the next tick comes 8 edges later.
4. `rate_sel`=01, drop `run` at `count`=2 for 5 cycles -> `count` holds 2 and `tick`=0; after `run`=1, the tick arrives exactly 3 edges later.
5. Assert `clear` asynchronously between edges while `count`=5 (sel 10) -> `count`=0 and `tick`=0 before the next edge; re-run of scenario 2's check passes.
6. RATE_STEP_EN, `run`=0 with `step_n` pulsed low for 4 cycles -> exactly one `tick`, 3 edges after the fall. The same pulse with `run`=1 -> no extra tick.

Source files
------------

// File: rtl/rate_divider_tick.sv
// rate_divider_tick: divides clk into a registered one-cycle tick at a switch-selected rate.
// Optional macro RATE_STEP_EN adds the step_n pushbutton for single-stepping while paused.
module rate_divider_tick #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned CNT_W  = 28
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic [1:0]       rate_sel,
`ifdef RATE_STEP_EN
  input  logic             step_n,
`endif
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  // Reload values are formed at 64 bits, then sized to the counter.
  localparam logic [63:0]      HZ64 = 64'(CLK_HZ);
  localparam logic [CNT_W-1:0] R1   = CNT_W'(HZ64 - 64'd1);
  localparam logic [CNT_W-1:0] R2   = CNT_W'((HZ64 << 1) - 64'd1);
  localparam logic [CNT_W-1:0] R3   = CNT_W'((HZ64 << 2) - 64'd1);

  function automatic logic [CNT_W-1:0] reload_val(input logic [1:0] s);
    case (s)
      2'b00:   reload_val = '0;
      2'b01:   reload_val = R1;
      2'b10:   reload_val = R2;
      default: reload_val = R3;
    endcase
  endfunction

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic [1:0]       sel_q;
  logic             step_fall;

`ifdef RATE_STEP_EN
  logic [1:0] step_sync_q;
  logic       step_prev_q;

  // Idle-high pushbutton: synchronizer and edge history reset to 1 so release from clear is not a fall.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      step_sync_q <= 2'b11;
      step_prev_q <= 1'b1;
    end else begin
      step_sync_q <= {step_sync_q[0], step_n};
      step_prev_q <= step_sync_q[1];
    end
  end

  assign step_fall = step_prev_q & ~step_sync_q[1];
`else
  assign step_fall = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    count_d = count_q;
    tick_d  = 1'b0;
    if (rate_sel != sel_q) begin
      count_d = reload_val(rate_sel);
    end else if (!run) begin
      tick_d = step_fall;
    end else if (count_q == '0) begin
      count_d = reload_val(sel_q);
      tick_d  = 1'b1;
    end else begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      sel_q   <= 2'b00;
    end else begin
      // NOTE: state updates use <= so every flop samples pre-edge values.
      count_q <= count_d;
      tick_q  <= tick_d;
      sel_q   <= rate_sel;
    end
  end

  assign tick  = tick_q;
  assign count = count_q;

endmodule

// File: tb/tb_rate_divider_tick.sv
// Scoreboard bench for rate_divider_tick at CLK_HZ=4 (reloads 0/3/7/15).
// Stimulus pushes hand-computed expectations; a monitor pops and compares after each edge.
module tb_rate_divider_tick;

  localparam int unsigned CNT_W = 28;

  typedef struct {
    logic        tick;
    logic [31:0] count;
    string       name;
  } exp_t;

  logic             clk = 1'b0;
  logic             clear = 1'b1;
  logic             run = 1'b0;
  logic [1:0]       rate_sel = 2'b00;
  logic             step_n = 1'b1;
  logic             tick;
  logic [CNT_W-1:0] count;

  exp_t sb[$];
  event sample_ev;
  int   total = 0;
  int   bad = 0;

  rate_divider_tick #(.CLK_HZ(4), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .clear    (clear),
    .run      (run),
    .rate_sel (rate_sel),
`ifdef RATE_STEP_EN
    .step_n   (step_n),
`endif
    .tick     (tick),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".tick"}, {31'd0, tick}, {31'd0, e.tick});
        check({e.name, ".count"}, 32'(count), e.count);
      end
    end
  end

  // Called at a falling edge: apply inputs, expect the result of the next rising edge.
  task automatic cyc(input logic r, input logic [1:0] s, input logic et, input int ec, input string nm);
    exp_t e;
    run      = r;
    rate_sel = s;
    e.tick   = et;
    e.count  = 32'(ec);
    e.name   = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Asserts clear mid-cycle and expects reset values before the next rising edge.
  task automatic do_clear(input string nm);
    exp_t e;
    #2;
    clear   = 1'b1;
    e.tick  = 1'b0;
    e.count = 32'd0;
    e.name  = nm;
    sb.push_back(e);
    ->sample_ev;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic scen2(input string nm);
    cyc(1'b1, 2'b01, 1'b0, 3, {nm, "_load"});
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 2'b01, 1'b0, 2, {nm, "_c2"});
      cyc(1'b1, 2'b01, 1'b0, 1, {nm, "_c1"});
      cyc(1'b1, 2'b01, 1'b0, 0, {nm, "_c0"});
      cyc(1'b1, 2'b01, 1'b1, 3, {nm, "_tick"});
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    @(negedge clk);
    do_clear("reset");

    // Select 00: tick on every edge from the first, count stays 0.
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, 1'b1, 0, "sel00");
    do_clear("clear_drops_tick");

    scen2("sel01");

    // Rate change 11 -> 10 at count 9.
    do_clear("clear3");
    cyc(1'b1, 2'b11, 1'b0, 15, "sel11_load");
    for (int c = 14; c >= 9; c--) cyc(1'b1, 2'b11, 1'b0, c, "sel11_dec");
    cyc(1'b1, 2'b10, 1'b0, 7, "change_10");
    for (int c = 6; c >= 0; c--) cyc(1'b1, 2'b10, 1'b0, c, "sel10_dec");
    cyc(1'b1, 2'b10, 1'b1, 7, "sel10_tick");

    // Pause at count 2 for 5 cycles, then resume.
    do_clear("clear4");
    cyc(1'b1, 2'b01, 1'b0, 3, "p_load");
    cyc(1'b1, 2'b01, 1'b0, 2, "p_dec");
    for (int i = 0; i < 5; i++) cyc(1'b0, 2'b01, 1'b0, 2, "paused");
    cyc(1'b1, 2'b01, 1'b0, 1, "resume1");
    cyc(1'b1, 2'b01, 1'b0, 0, "resume2");
    cyc(1'b1, 2'b01, 1'b1, 3, "resume_tick");

    // Rate change while paused: the change wins and loads the new reload.
    cyc(1'b0, 2'b10, 1'b0, 7, "chg_paused");
    cyc(1'b0, 2'b10, 1'b0, 7, "hold_paused");
    cyc(1'b1, 2'b10, 1'b0, 6, "run_again");
    cyc(1'b1, 2'b10, 1'b0, 5, "at5");

    // Asynchronous clear at count 5, then the sel 01 sequence again.
    do_clear("async_clear");
    scen2("rerun");

`ifdef RATE_STEP_EN
    do_clear("clear6");
    cyc(1'b0, 2'b01, 1'b0, 3, "st_load");
    step_n = 1'b0;
    cyc(1'b0, 2'b01, 1'b0, 3, "st_e1");
    cyc(1'b0, 2'b01, 1'b0, 3, "st_e2");
    cyc(1'b0, 2'b01, 1'b1, 3, "st_tick");
    cyc(1'b0, 2'b01, 1'b0, 3, "st_e4");
    step_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b01, 1'b0, 3, "st_rel");
    step_n = 1'b0;
    cyc(1'b1, 2'b01, 1'b0, 2, "st_run1");
    cyc(1'b1, 2'b01, 1'b0, 1, "st_run2");
    cyc(1'b1, 2'b01, 1'b0, 0, "st_run3");
    cyc(1'b1, 2'b01, 1'b1, 3, "st_run4");
    step_n = 1'b1;
    cyc(1'b1, 2'b01, 1'b0, 2, "st_run5");
`endif

    repeat (3) @(posedge clk);
    #2;
    check("drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
